mini_proc_gen: RTL
==================

# mini_proc_gen

Parametrised second-generation mini processor. It executes one instruction per `Run` request from an external instruction/data stream on `DIN`. Compared with the 8-bit, 8-register, 4-opcode processor it replaces, it adds:
- configurable data width and register count;
- a 3-bit opcode with logic operations, a conditional move and a two-word immediate;
- zero and carry flags.

It sits in the same place in the system: driven by a sequencer or testbench through `Run`/`DIN`, with `Bus`, `Done` and the register file exposed for observation.

## Interface
- `DW`, default 16 – data/register width; `DW >= IW` is required.
- `NR`, default 8 – number of registers; power of two, 2..16.
- `RW`, default `$clog2(NR)` – register index width (derived; do not override).
- `IW`, default `3+2*RW` – instruction width (derived).

Ports:
- `Clock`  in  1 – single clock; all state changes on the rising edge.
- `Reset`  in  1 – asynchronous, active-high reset.
- `Run`  in  1 – start request; sampled only in state T0.
- `DIN`  in  DW – instruction word in T0; immediate word in T1 of `mvi`.
- `Done`  out  1 – combinational; high for exactly the final cycle of an instruction.
- `Busy`  out  1 – high whenever state ≠ T0.
- `Bus`  out  DW – internal bus value (combinational mux).
- `Z`  out  1 – zero flag.
- `C`  out  1 – carry/borrow flag.
- `R_flat`  out  NR*DW – register file; `Rk = R_flat[k*DW +: DW]`.

## Operation
- **Instruction format:** `DIN[IW-1:IW-3]` = opcode, `DIN[2*RW-1:RW]` = X, `DIN[RW-1:0]` = Y. Bits above `IW` are ignored.
- **Opcodes:**
  - `000 mv` – Rx←Ry.
  - `001 mvi` – Rx←next DIN word.
  - `010 add` – Rx←Rx+Ry.
  - `011 sub` – Rx←Rx−Ry.
  - `100 and`, `101 or`, `110 xor` – Rx←Rx op Ry.
  - `111 mvnz` – Rx←Ry only if Z==0.
- **FSM states:** T0 (idle/fetch), T1, T2, T3.
  - T0: Bus=0. If Run=1, IR←DIN[IW-1:0] and go to T1; otherwise stay in T0.
  - T1, `mv`: Bus=Ry, Rx←Bus, Done=1, go to T0.
  - T1, `mvi`: Bus=DIN, Rx←DIN, Done=1, go to T0.
  - T1, `mvnz`: Bus=Ry, Done=1, go to T0. Rx is written only if Z==0.
  - T1, ALU ops: Bus=Rx, A←Bus, go to T2.
  - T2: Bus=Ry, G←A op Ry, flags updated, go to T3.
  - T3: Bus=G, Rx←G, Done=1, go to T0.
- **Arithmetic:**
  - `add` is modulo 2^DW; C = carry-out.
  - `sub` is modulo 2^DW; C = 1 when Rx<Ry (borrow).
  - Logic ops force C=0.
  - Z = (result == 0).
  - Flags change only in T2 of ALU ops; `mv`, `mvi` and `mvnz` leave them unchanged.
- X==Y is legal: `add R3,R3` doubles R3, `sub R3,R3` gives 0 with Z=1, `xor R3,R3` gives 0.
- Run is ignored in T1–T3. Instructions issued while Busy are lost, not queued.
- `Busy` = (state ≠ T0); `Done` is asserted only in the final state.

## Timing
- **Reset (async, immediate):**
  - state=T0, all registers 0, IR=A=G=0, Z=0, C=0.
  - Done=0, Busy=0, Bus=0.
- **Reset mid-instruction:** the instruction is aborted with no register write, even if asserted in T3.
- **Latency:**
  - Run is sampled at rising edge n.
  - `mv`/`mvi`/`mvnz`: Done is high during cycle n+1, and the write occurs at edge n+2.
  - ALU ops: Done is high during cycle n+3, and the write occurs at edge n+4.
- **Back-to-back issue:** Run may be asserted in the T0 cycle immediately after Done. There are no idle cycles mandatory, giving a sustained 2 or 4 cycles per instruction.
- **Run held high:** with Run continuously high, a new instruction is fetched in every T0.
- **`mvi` immediate:** the immediate must be valid on DIN throughout the T1 cycle. Run is don't-care in that cycle.

## Test plan
1. **Reset and `mvi`:** Reset, then `mvi R3,0x1234` → Done=1 and Bus=0x1234 exactly one cycle after Run; R3=0x1234; other registers 0; Done low in the following cycle.
2. **`add` overflow:** R0=0xFFFF, R1=0x0002, `add R0,R1` → Busy for 3 cycles, Done only in T3 with Bus=0x0001; R0=0x0001, C=1, Z=0.
3. **`sub` to zero and `mvnz`:** R2=R5=0x00AA, `sub R2,R5` → R2=0, Z=1, C=0. Then `mvnz R4,R5` → Done=1 and R4 unchanged. Then `xor R6,R5` (R6=0x00FF) gives Z=0, and a following `mvnz R4,R5` → R4=0x00AA.
4. **Logic and flag preservation:** R1=0xF0F0, R2=0x3C3C → `and` gives 0x3030, `or` gives 0xFCFC, `xor` gives 0xCCCC, each with C=0. An interleaved `mv` leaves Z/C unchanged.
5. **Reset abort:** assert Reset in T2 of `add R0,R1` → Done=0, Busy=0, Bus=0 immediately; all registers 0; R0 not written.
6. **Run during Busy, back-to-back, parameter sweep:**
   - Pulse Run with a `mv` instruction during T2 of an `add` → it is ignored.
   - Hold Run high across a mv, add, mv sequence → Done at cycles 1, 5, 7.
   - Repeat scenarios 1–3 with DW=8, NR=4 (IW=7).

Source files
------------

// File: rtl/mini_proc_gen.sv
// rtl/mini_proc_gen.sv - multi-cycle mini processor with parametrised width, register count and Z/C flags
module mini_proc_gen #(
    parameter int DW = 16,
    parameter int NR = 8,
    parameter int RW = $clog2(NR),
    parameter int IW = 3 + 2*RW
) (
    input  logic             Clock,
    input  logic             Reset,
    input  logic             Run,
    input  logic [DW-1:0]    DIN,
    output logic             Done,
    output logic             Busy,
    output logic [DW-1:0]    Bus,
    output logic             Z,
    output logic             C,
    output logic [NR*DW-1:0] R_flat
);
    typedef enum logic [1:0] {T0, T1, T2, T3} state_t;
    typedef enum logic [2:0] {
        OP_MV, OP_MVI, OP_ADD, OP_SUB, OP_AND, OP_OR, OP_XOR, OP_MVNZ
    } op_t;

    state_t        state;
    logic [IW-1:0] ir;
    logic [DW-1:0] a;
    logic [DW-1:0] g;
    logic [DW-1:0] regs [NR];

    op_t           opcode;
    logic [RW-1:0] rx;
    logic [RW-1:0] ry;
    logic [DW-1:0] reg_x;
    logic [DW-1:0] reg_y;
    logic          short_op;
    logic [DW-1:0] alu_res;
    logic          alu_c;

    assign opcode   = op_t'(ir[IW-1 -: 3]);
    assign rx       = ir[2*RW-1:RW];
    assign ry       = ir[RW-1:0];
    assign reg_x    = regs[rx];
    assign reg_y    = regs[ry];
    assign short_op = (opcode == OP_MV) || (opcode == OP_MVI) || (opcode == OP_MVNZ);

    assign Busy = (state != T0);
    assign Done = ((state == T1) && short_op) || (state == T3);

    always_comb begin
        Bus = '0;
        case (state)
            T0: Bus = '0;
            T1: begin
                if (opcode == OP_MVI)
                    Bus = DIN;
                else if (short_op)
                    Bus = reg_y;
                else
                    Bus = reg_x;
            end
            T2: Bus = reg_y;
            T3: Bus = g;
            default: Bus = '0;
        endcase
    end

    // Subtraction borrow is simply Rx < Ry on the unsigned operands.
    always_comb begin
        alu_res = '0;
        alu_c   = 1'b0;
        case (opcode)
            OP_ADD: {alu_c, alu_res} = {1'b0, a} + {1'b0, reg_y};
            OP_SUB: begin
                alu_res = a - reg_y;
                alu_c   = (a < reg_y);
            end
            OP_AND: alu_res = a & reg_y;
            OP_OR:  alu_res = a | reg_y;
            OP_XOR: alu_res = a ^ reg_y;
            default: begin
                alu_res = '0;
                alu_c   = 1'b0;
            end
        endcase
    end

    always_ff @(posedge Clock or posedge Reset) begin
        if (Reset) begin
            state <= T0;
            ir    <= '0;
            a     <= '0;
            g     <= '0;
            Z     <= 1'b0;
            C     <= 1'b0;
            for (int k = 0; k < NR; k++)
                regs[k] <= '0;
        end else begin
            case (state)
                T0: begin
                    if (Run) begin
                        ir    <= DIN[IW-1:0];
                        state <= T1;
                    end
                end
                T1: begin
                    case (opcode)
                        OP_MV: begin
                            regs[rx] <= reg_y;
                            state    <= T0;
                        end
                        OP_MVI: begin
                            regs[rx] <= DIN;
                            state    <= T0;
                        end
                        OP_MVNZ: begin
                            if (!Z)
                                regs[rx] <= reg_y;
                            state <= T0;
                        end
                        default: begin
                            a     <= Bus;
                            state <= T2;
                        end
                    endcase
                end
                T2: begin
                    g     <= alu_res;
                    C     <= alu_c;
                    Z     <= (alu_res == '0);
                    state <= T3;
                end
                T3: begin
                    regs[rx] <= g;
                    state    <= T0;
                end
                default: state <= T0;
            endcase
        end
    end

    for (genvar k = 0; k < NR; k++) begin : g_flat
        assign R_flat[k*DW +: DW] = regs[k];
    end
endmodule
